// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: func3 codes, FSM encoding and
// the round-robin pick helper.
package alu_scheduler_pkg;

  localparam logic [2:0] FUNC_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNC_SLL     = 3'b001;
  localparam logic [2:0] FUNC_SLT     = 3'b010;
  localparam logic [2:0] FUNC_SLTU    = 3'b011;
  localparam logic [2:0] FUNC_XOR     = 3'b100;
  localparam logic [2:0] FUNC_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNC_OR      = 3'b110;
  localparam logic [2:0] FUNC_AND     = 3'b111;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo num_req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int num_req);
    logic [2:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % num_req);
      if (!found && (k < num_req) && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester-side bus of the ALU scheduler: per-requester operation request
// channel and one-hot registered response channel.
interface alu_scheduler_if #(
  parameter int SIZE    = 32,
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [3*NUM_REQ-1:0]    req_func;
  logic [NUM_REQ-1:0]      req_f7;
  logic [SIZE*NUM_REQ-1:0] req_a;
  logic [SIZE*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready;
  logic [SIZE-1:0]         resp_data;

  modport master (
    output req_valid, req_func, req_f7, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_func, req_f7, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_scheduler_alu.sv
// Combinational RV32-style integer ALU selected by func3 and funct7 bit 5.
module alu_scheduler_alu
  import alu_scheduler_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [2:0]      func,
  input  logic            f7,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] result
);

  logic [4:0] shamt_s;

  // Operation decode; shift amount is always the low five bits of b.
  always_comb begin
    shamt_s = b[4:0];
    case (func)
      FUNC_ADD_SUB: result = f7 ? (a - b) : (a + b);
      FUNC_SLL:     result = a << shamt_s;
      FUNC_SLT:     result = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      FUNC_SLTU:    result = {{(SIZE-1){1'b0}}, (a < b)};
      FUNC_XOR:     result = a ^ b;
      FUNC_SRL_SRA: result = f7 ? $unsigned($signed(a) >>> shamt_s) : (a >> shamt_s);
      FUNC_OR:      result = a | b;
      FUNC_AND:     result = a & b;
      default:      result = {SIZE{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one ALU between NUM_REQ requesters with a
// valid/ready request channel and a registered one-hot response channel.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  alu_scheduler_if.slave     bus,
  output logic               busy
);

  state_t              state_r, state_nxt_s;
  logic [2:0]          rr_ptr_r, grant_r, pick_s;
  logic [2:0]          func_r, sel_func_s;
  logic                f7_r, sel_f7_s;
  logic [SIZE-1:0]     a_r, b_r, sel_a_s, sel_b_s;
  logic [SIZE-1:0]     resp_data_r, alu_result_s;
  logic [NUM_REQ-1:0]  resp_valid_r, ready_s, grant_oh_s;
  logic [MAX_REQ-1:0]  valid_ext_s;
  logic                accept_s, resp_ack_s;

  // Round-robin pick and operand selection for the candidate requester.
  always_comb begin
    valid_ext_s              = {MAX_REQ{1'b0}};
    valid_ext_s[NUM_REQ-1:0] = bus.req_valid;
    pick_s     = rr_pick(valid_ext_s, rr_ptr_r, NUM_REQ);
    sel_func_s = 3'd0;
    sel_f7_s   = 1'b0;
    sel_a_s    = {SIZE{1'b0}};
    sel_b_s    = {SIZE{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_func_s = sel_func_s | (bus.req_func[3*i +: 3] & {3{pick_s == 3'(i)}});
      sel_f7_s   = sel_f7_s | (bus.req_f7[i] & (pick_s == 3'(i)));
      sel_a_s    = sel_a_s | (bus.req_a[SIZE*i +: SIZE] & {SIZE{pick_s == 3'(i)}});
      sel_b_s    = sel_b_s | (bus.req_b[SIZE*i +: SIZE] & {SIZE{pick_s == 3'(i)}});
      grant_oh_s[i] = (grant_r == 3'(i));
    end
    resp_ack_s = |(bus.resp_ready & grant_oh_s);
  end

  // Next-state logic and combinational grant.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.req_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (resp_ack_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = accept_s && (pick_s == 3'(i));
    end
  end

  alu_scheduler_alu #(.SIZE(SIZE)) u_alu (
    .func   (func_r),
    .f7     (f7_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result_s)
  );

  // State, operand latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= 3'd0;
      grant_r      <= 3'd0;
      func_r       <= 3'd0;
      f7_r         <= 1'b0;
      a_r          <= {SIZE{1'b0}};
      b_r          <= {SIZE{1'b0}};
      resp_valid_r <= {NUM_REQ{1'b0}};
      resp_data_r  <= {SIZE{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        grant_r  <= pick_s;
        rr_ptr_r <= (pick_s == 3'(NUM_REQ - 1)) ? 3'd0 : (pick_s + 3'd1);
        func_r   <= sel_func_s;
        f7_r     <= sel_f7_s;
        a_r      <= sel_a_s;
        b_r      <= sel_b_s;
      end
      if (state_r == EXEC) begin
        resp_data_r  <= alu_result_s;
        resp_valid_r <= grant_oh_s;
      end else if ((state_r == RESP) && resp_ack_s) begin
        resp_valid_r <= {NUM_REQ{1'b0}};
      end
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign busy           = (state_r != IDLE);

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
Shares the single combinational ALU between NUM_REQ requesters, e.g. PC increment, load/store address generation and instruction execute. Arbitration is round-robin. Each requester issues an operation with a valid/ready handshake and receives its result through a registered, one-hot response channel. The block sits between the core control FSM and the ALU instance and is the only driver of the ALU inputs.

Parameters:
SIZE, 32, operand/result width in bits
NUM_REQ, 3, number of requesters (2..8)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  one-hot grant; request accepted on the cycle where valid and ready are both high
req_func  input  3*NUM_REQ  func3 per requester, slice i = [3i+2:3i]
req_f7  input  NUM_REQ  funct7 bit 5 per requester (SUB/SRA select)
req_a  input  SIZE*NUM_REQ  operand 1 per requester, slice i = [SIZE*i+SIZE-1:SIZE*i]
req_b  input  SIZE*NUM_REQ  operand 2 per requester
resp_valid  output  NUM_REQ  one-hot result valid for the granted requester
resp_ready  input  NUM_REQ  per-requester result accept
resp_data  output  SIZE  result of the current response
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst high at edge): state=IDLE, rr_ptr=0, grant register=0, resp_valid=0, resp_data=0, operand registers=0. Reset has priority over every other event.
- Reset mid-operation aborts the operation silently. No resp_valid is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick g = first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Drive req_ready = one-hot(g) combinationally in the same cycle. Only one bit may ever be set.
  - At the edge, latch req_func/req_f7/req_a/req_b slice g, store g, set rr_ptr=(g+1) mod NUM_REQ, and go to EXEC.
  - If no request is present, stay in IDLE with req_ready=0.
- EXEC:
  - The ALU is driven from the latched operands. At the edge the result is registered into resp_data; go to RESP.
  - req_ready=0.
- RESP:
  - resp_valid = one-hot(g). resp_data is held stable.
  - When resp_ready[g]=1: at the edge go to IDLE, clear resp_valid, and keep resp_data at its last value.
  - resp_ready bits of other requesters are ignored.
  - Otherwise stay in RESP indefinitely.
- Latency: accept at cycle T, resp_valid from T+2. Minimum issue interval is 3 cycles, since no new grant happens in RESP or EXEC.
- req_ready is 0 in every state except IDLE. A requester dropping valid is legal. Operand changes after acceptance have no effect.
- ALU semantics (func3):
  - 000: ADD, or SUB when f7=1.
  - 001: SLL.
  - 010: SLT, signed.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when f7=1.
  - 110: OR.
  - 111: AND.
- Width rules: shift amount is b[4:0]. Results are modulo 2^SIZE with wrap-around and no overflow flag. SLT/SLTU return 1 or 0, zero-extended to SIZE. SRA fills with a[SIZE-1].
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep valid asserted and win later. Round-robin guarantees each waiting requester is served within NUM_REQ grants.
- rr_ptr wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package holds:
  - func3 localparams (FUNC_ADD_SUB … FUNC_AND);
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - a helper function for the round-robin priority pick.
- One sub-module: the existing alu, instantiated once with size=SIZE and driven only from the latched operand registers. The scheduler contains no arithmetic of its own.

Test Plan:
- Single requester 0, ADD, a=5, b=7, resp_ready tied 1:
  - req_ready[0]=1 at T, busy at T+1;
  - resp_valid=3'b001, resp_data=12 at T+2;
  - IDLE at T+3.
- Requester 1, SUB f7=1, a=0, b=1 -> resp_data=32'hFFFFFFFF. Then SRA f7=1, a=32'h80000000, b=4 -> 32'hF8000000. Then SLT a=-1, b=0 -> 1, and SLTU with the same operands -> 0.
- All three requesters held valid from reset: grant order 0,1,2,0,1. Each response is delivered only to resp_valid of the granted index.
- Backpressure: resp_ready=0 for 5 cycles in RESP, with a different requester raising valid meanwhile:
  - resp_valid and resp_data stay stable;
  - req_ready stays 0;
  - after resp_ready[g] the next grant goes to the waiting requester.
- Reset asserted during EXEC: next cycle state IDLE, resp_valid=0, resp_data=0, rr_ptr=0. No response appears for the aborted op.
- SLL with b=32'h00000021 (shift 1), a=3 -> 6. SRL with b=31, a=32'h80000000 -> 1.
